// File: rtl/switch_pkg.sv
// Shared types and defaults for the switch ingress path.
// The arbiter FSM encoding and the switch port widths live here.
package switch_pkg;

  localparam int SW_ADDR_W = 8;
  localparam int SW_DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Modulo increment that also works when n is not a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/switch_ingress_arb_rr_pick.sv
// Rotate-priority find-first: returns the first set request at or after ptr,
// searching upward and wrapping from NREQ-1 back to 0.
module rr_pick #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // Walk from the lowest priority to the highest so the last hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/switch_ingress_arb.sv
// Round-robin ingress arbiter sharing the switch input port between NREQ
// requesters, with bursts of up to BURST_MAX beats and one registered output stage.
module switch_ingress_arb
  import switch_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int ADDR_W    = SW_ADDR_W,
  parameter  int DATA_W    = SW_DATA_W,
  parameter  int BURST_MAX = 4,
  localparam int IDX_W     = $clog2(NREQ),
  localparam int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_vld,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_rdy,
  input  logic                     out_rdy,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        data,
  output logic                     vld,
  output logic [IDX_W-1:0]         gnt_id,
  output logic                     busy
);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vld_q, vld_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               slot_free;
  logic               owner_vld;
  logic               xfer;
  logic               last_beat;
  logic [ADDR_W-1:0]  owner_addr;
  logic [DATA_W-1:0]  owner_data;

  logic [ADDR_W-1:0]  slot_addr [NREQ];
  logic [DATA_W-1:0]  slot_data [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slot_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign slot_data[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req_vld),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign slot_free  = !vld_q || out_rdy;
  assign owner_vld  = req_vld[owner_q];
  assign owner_addr = slot_addr[owner_q];
  assign owner_data = slot_data[owner_q];
  assign xfer       = (state_q == OWN) && slot_free && owner_vld;
  assign last_beat  = (cnt_q == CNT_W'(BURST_MAX - 1));

  // Ready depends only on registered state plus out_rdy, never on req_vld.
  always_comb begin
    req_rdy = '0;
    if ((state_q == OWN) && slot_free) begin
      req_rdy[owner_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        // A dropped request releases even while the output is stalled.
        if (!owner_vld || (xfer && last_beat)) begin
          state_d = IDLE;
          ptr_d   = IDX_W'(wrap_inc(int'(owner_q), NREQ));
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slot holds while stalled, otherwise reloads or empties.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (slot_free) begin
      vld_d = xfer;
      if (xfer) begin
        addr_d = owner_addr;
        data_d = owner_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign addr   = addr_q;
  assign data   = data_q;
  assign vld    = vld_q;
  assign gnt_id = owner_q;
  assign busy   = (state_q == OWN);

endmodule

// File: tb/tb_switch_ingress_arb.sv
// Directed bench for switch_ingress_arb with a per-requester scoreboard
// fed at stimulus time and drained by an independent output monitor.
module tb_switch_ingress_arb;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int BM   = 4;

  logic               clk;
  logic               rstn;
  logic [NREQ-1:0]    req_vld;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_rdy;
  logic               out_rdy;
  logic [AW-1:0]      addr;
  logic [DW-1:0]      data;
  logic               vld;
  logic [1:0]         gnt_id;
  logic               busy;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t stim_q [NREQ][$];
  beat_t exp_q  [NREQ][$];
  int    accept_log [$];

  int tests_run    = 0;
  int tests_failed = 0;

  bit            prev_fire;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  switch_ingress_arb #(
    .NREQ      (NREQ),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BURST_MAX (BM)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_vld  (req_vld),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .out_rdy  (out_rdy),
    .addr     (addr),
    .data     (data),
    .vld      (vld),
    .gnt_id   (gnt_id),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (stim_q[i].size() != 0) begin
        req_vld[i]            = 1'b1;
        req_addr[i*AW +: AW]  = stim_q[i][0].addr;
        req_data[i*DW +: DW]  = stim_q[i][0].data;
      end else begin
        req_vld[i] = 1'b0;
      end
    end
  endtask

  task automatic apply_stimulus(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    beat_t b;
    b.addr = a;
    b.data = d;
    stim_q[id].push_back(b);
    exp_q[id].push_back(b);
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_reqs();
  endtask

  function automatic bit exp_empty();
    for (int i = 0; i < NREQ; i++) begin
      if (exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < NREQ; i++) begin
      stim_q[i].delete();
      exp_q[i].delete();
    end
    accept_log.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_vld"},     32'(vld),     32'd0);
    check_output({tag, "_addr"},    32'(addr),    32'd0);
    check_output({tag, "_data"},    32'(data),    32'd0);
    check_output({tag, "_req_rdy"}, 32'(req_rdy), 32'd0);
    check_output({tag, "_gnt_id"},  32'(gnt_id),  32'd0);
    check_output({tag, "_busy"},    32'(busy),    32'd0);
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    out_rdy = 1'b1;
    clear_queues();
    drive_reqs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_accepts(input string name, input int n, input int limit);
    int c;
    c = 0;
    while (accept_log.size() < n && c < limit) begin
      cycle();
      c++;
    end
    check_output(name, 32'(accept_log.size()), 32'(n));
  endtask

  task automatic wait_drain(input string name, input int limit);
    int c;
    bit done;
    c = 0;
    done = 1'b0;
    while (!done && c < limit) begin
      cycle();
      c++;
      done = !vld && !busy && exp_empty();
    end
    check_output(name, 32'(done), 32'd1);
  endtask

  task automatic check_log_entry(input string name, input int n, input int exp_id);
    int got;
    got = (n < accept_log.size()) ? accept_log[n] : -1;
    check_output($sformatf("%s[%0d]", name, n), 32'(got), 32'(exp_id));
  endtask

  // Handshake tracker, latency check and scoreboard drain on every rising edge.
  task automatic monitor_loop();
    forever begin
      @(posedge clk);
      if (!rstn) begin
        prev_fire = 1'b0;
      end else begin
        int    hit;
        string heads;
        if (prev_fire) begin
          check_output("latency_vld",  32'(vld),  32'd1);
          check_output("latency_addr", 32'(addr), 32'(prev_addr));
          check_output("latency_data", 32'(data), 32'(prev_data));
        end
        prev_fire = 1'b0;
        check_output("rdy_onehot", 32'($countones(req_rdy) <= 1), 32'd1);
        for (int i = 0; i < NREQ; i++) begin
          if (req_vld[i] && req_rdy[i] && stim_q[i].size() != 0) begin
            prev_fire = 1'b1;
            prev_addr = req_addr[i*AW +: AW];
            prev_data = req_data[i*DW +: DW];
            accept_log.push_back(i);
            void'(stim_q[i].pop_front());
          end
        end
        if (vld && out_rdy) begin
          hit = -1;
          heads = "";
          for (int j = 0; j < NREQ; j++) begin
            if (exp_q[j].size() != 0) begin
              heads = {heads, $sformatf(" r%0d=%h/%h", j, exp_q[j][0].addr, exp_q[j][0].data)};
              if (hit < 0 && exp_q[j][0].addr == addr && exp_q[j][0].data == data) hit = j;
            end else begin
              heads = {heads, $sformatf(" r%0d=empty", j)};
            end
          end
          tests_run++;
          if (hit < 0) begin
            tests_failed++;
            $display("[TB] FAIL sb_match: actual addr=%h data=%h, required one of FIFO heads%s", addr, data, heads);
          end else begin
            void'(exp_q[hit].pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    bit            trace [$];
    int            first;
    logic [23:0]   got_pat;
    logic [23:0]   exp_pat;
    int            pos;
    int            c;
    bit            seen;

    rstn      = 1'b1;
    out_rdy   = 1'b1;
    req_vld   = '0;
    req_addr  = '0;
    req_data  = '0;
    prev_fire = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    fork
      monitor_loop();
    join_none

    #1 rstn = 1'b0;
    #1 check_reset_outputs("reset");
    do_reset();

    // Test 1: single requester, 3 beats then release on dropped request.
    for (int k = 0; k < 3; k++) apply_stimulus(0, 8'(8'h10 + k), 16'(16'hA000 + k));
    drive_reqs();
    cycle();
    check_output("t1_busy_grant", 32'(busy),   32'd1);
    check_output("t1_gnt_id",     32'(gnt_id), 32'd0);
    wait_accepts("t1_accepts", 3, 20);
    wait_drain("t1_drain", 30);
    check_output("t1_gnt_hold", 32'(gnt_id), 32'd0);
    check_output("t1_busy_end", 32'(busy),   32'd0);
    for (int n = 0; n < 3; n++) check_log_entry("t1_order", n, 0);

    // Test 2: all requesters busy; bursts of 4 with one bubble each.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < 4; k++) apply_stimulus(i, 8'(8'h40 + i*16 + k), 16'(16'h1000*(i+1) + k));
    end
    for (int k = 4; k < 8; k++) apply_stimulus(0, 8'(8'h40 + k), 16'(16'h1000 + k));
    drive_reqs();
    trace.delete();
    for (int t = 0; t < 40; t++) begin
      cycle();
      trace.push_back(vld);
    end
    check_output("t2_accepts", 32'(accept_log.size()), 32'd20);
    for (int n = 0; n < 20; n++) check_log_entry("t2_order", n, (n < 16) ? n / 4 : 0);
    first = -1;
    for (int t = 0; t < trace.size(); t++) begin
      if (first < 0 && trace[t]) first = t;
    end
    got_pat = '0;
    for (int t = 0; t < 24; t++) begin
      if (first >= 0 && first + t < trace.size()) got_pat[23-t] = trace[first + t];
    end
    exp_pat = '0;
    pos = 0;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        exp_pat[23-pos] = 1'b1;
        pos++;
      end
      if (b < 4) pos++;
    end
    check_output("t2_bubble_pattern", 32'(got_pat), 32'(exp_pat));
    wait_drain("t2_drain", 20);

    // Test 3: downstream stall while a beat is presented.
    do_reset();
    apply_stimulus(1, 8'h22, 16'hBEEF);
    apply_stimulus(1, 8'h23, 16'hBEF0);
    apply_stimulus(1, 8'h24, 16'hBEF1);
    drive_reqs();
    c = 0;
    seen = 1'b0;
    while (!seen && c < 10) begin
      cycle();
      c++;
      seen = vld && (addr == 8'h22);
    end
    check_output("t3_first_beat_seen", 32'(seen), 32'd1);
    out_rdy = 1'b0;
    #1 check_output("t3_stall_rdy_now", 32'(req_rdy), 32'd0);
    for (int s = 0; s < 3; s++) begin
      cycle();
      check_output("t3_stall_vld",  32'(vld),     32'd1);
      check_output("t3_stall_addr", 32'(addr),    32'h22);
      check_output("t3_stall_data", 32'(data),    32'hBEEF);
      check_output("t3_stall_rdy",  32'(req_rdy), 32'd0);
    end
    out_rdy = 1'b1;
    wait_accepts("t3_accepts", 3, 20);
    wait_drain("t3_drain", 20);
    for (int n = 0; n < 3; n++) check_log_entry("t3_order", n, 1);

    // Test 4: owner drops after 2 beats, req3 waiting.
    do_reset();
    apply_stimulus(1, 8'h31, 16'h3100);
    apply_stimulus(1, 8'h32, 16'h3101);
    apply_stimulus(3, 8'h33, 16'h3300);
    apply_stimulus(3, 8'h34, 16'h3301);
    drive_reqs();
    cycle();
    check_output("t4_busy_n1", 32'(busy),   32'd1);
    check_output("t4_gnt_n1",  32'(gnt_id), 32'd1);
    repeat (3) cycle();
    check_output("t4_idle_busy", 32'(busy),   32'd0);
    check_output("t4_idle_gnt",  32'(gnt_id), 32'd1);
    cycle();
    check_output("t4_next_busy", 32'(busy),   32'd1);
    check_output("t4_next_gnt",  32'(gnt_id), 32'd3);
    wait_accepts("t4_accepts", 4, 20);
    for (int n = 0; n < 4; n++) check_log_entry("t4_order", n, (n < 2) ? 1 : 3);
    wait_drain("t4_drain", 20);

    // Test 5: async reset mid-burst, then pointer restarts from 0.
    do_reset();
    apply_stimulus(2, 8'h60, 16'h6000);
    for (int k = 0; k < 4; k++) apply_stimulus(3, 8'(8'h70 + k), 16'(16'h7000 + k));
    drive_reqs();
    wait_accepts("t5_pre_accepts", 3, 20);
    check_log_entry("t5_pre_order", 0, 2);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1 check_reset_outputs("t5_async");
    clear_queues();
    drive_reqs();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 2; k++) apply_stimulus(2, 8'(8'h62 + k), 16'(16'h6200 + k));
    for (int k = 0; k < 4; k++) apply_stimulus(3, 8'(8'h74 + k), 16'(16'h7400 + k));
    drive_reqs();
    wait_accepts("t5_accepts", 6, 40);
    for (int n = 0; n < 6; n++) check_log_entry("t5_order", n, (n < 2) ? 2 : 3);
    wait_drain("t5_drain", 20);

    // Test 6: pointer wrapped to 0 after req3; req0 beats req2.
    accept_log.delete();
    apply_stimulus(0, 8'h80, 16'h8000);
    apply_stimulus(0, 8'h81, 16'h8001);
    apply_stimulus(2, 8'h82, 16'h8200);
    apply_stimulus(2, 8'h83, 16'h8201);
    drive_reqs();
    wait_accepts("t6_accepts", 4, 20);
    for (int n = 0; n < 4; n++) check_log_entry("t6_order", n, (n < 2) ? 0 : 2);
    wait_drain("t6_drain", 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
